// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch entry layout and the canonical NOP.
// Decode substitutes NOP_INSTR for bubbles when no fetched entry is available.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_queue_fifo.sv
// Synchronous prefetch FIFO with flush, occupancy count and a combinational head.
// The head reads as zero whenever the FIFO is empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    always_comb begin
        w_pop  = pop && (r_count != '0);
        w_push = push && ((r_count != CW'(DEPTH)) || w_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wrPtr] <= wdata;
    end

    assign head  = (r_count != '0) ? r_mem[r_rdPtr] : '0;
    assign count = r_count;

endmodule

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: pipelined in-order imem requests feeding a prefetch FIFO
// that hands {pc, instr} pairs to decode; redirects flush the FIFO and drop in-flight responses.
module riscv_fetch_queue #(
    parameter int              XLEN            = riscv_pkg::XLEN,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [31:0]     dec_instr,
    output logic [XLEN-1:0] dec_pc
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0]    r_fetchPc;
    logic [XLEN-1:0]    r_respPc;
    logic [CW-1:0]      r_outstanding;
    logic [CW-1:0]      r_dropCnt;
    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_outNext;
    logic [XLEN-1:0]    w_redirPc;
    logic [XLEN+31:0]   w_head;
    logic               w_credit;
    logic               w_issue;
    logic               w_keep;

    // Credit counts FIFO entries plus in-flight requests, so every kept response has a slot.
    always_comb begin
        w_credit  = (r_outstanding < CW'(MAX_OUTSTANDING))
                 && (({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH));
        imem_req  = !reset && !redirect_valid && w_credit;
        w_issue   = imem_req && imem_gnt;
        w_outNext = r_outstanding + CW'(w_issue) - CW'(imem_rvalid && (r_outstanding != '0));
        w_keep    = imem_rvalid && (r_dropCnt == '0) && !redirect_valid;
        w_redirPc = redirect_pc & ~XLEN'(3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetchPc     <= RESET_PC;
            r_respPc      <= RESET_PC;
            r_outstanding <= '0;
            r_dropCnt     <= '0;
        end else begin
            r_outstanding <= w_outNext;
            if (redirect_valid) begin
                r_fetchPc <= w_redirPc;
                r_respPc  <= w_redirPc;
                r_dropCnt <= w_outNext;
            end else begin
                if (w_issue) r_fetchPc <= r_fetchPc + XLEN'(4);
                if (w_keep)  r_respPc  <= r_respPc + XLEN'(4);
                if (imem_rvalid && (r_dropCnt != '0)) r_dropCnt <= r_dropCnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (w_keep),
        .pop   (dec_ready),
        .wdata ({r_respPc, imem_rdata}),
        .head  (w_head),
        .count (w_count)
    );

    assign imem_addr = r_fetchPc;
    assign dec_valid = (w_count != '0);
    assign dec_pc    = w_head[XLEN+31:32];
    assign dec_instr = w_head[31:0];

`ifndef SYNTHESIS
    a_countBound: assert property (@(posedge clk) disable iff (reset) w_count <= CW'(DEPTH));
    a_outBound:   assert property (@(posedge clk) disable iff (reset) r_outstanding <= CW'(MAX_OUTSTANDING));
    a_noStrayRsp: assert property (@(posedge clk) disable iff (reset) !(imem_rvalid && (r_outstanding == '0)));
    a_aligned:    assert property (@(posedge clk) disable iff (reset) imem_addr[1:0] == 2'b00);
`endif

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: a latency-configurable in-order memory model
// and hand-computed expected PCs/instructions for streaming, backpressure, redirects and reset.
module tb_riscv_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    int issueCount = 0;
    int popCount = 0;
    int base;

    logic        pipeV [8] = '{default: 1'b0};
    logic [31:0] pipeA [8] = '{default: 32'h0};

    riscv_fetch_queue #(
        .XLEN            (32),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2),
        .RESET_PC        (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h1357_0000;
    endfunction

    // In-order memory: an accepted request reappears as a response lat cycles later.
    always @(posedge clk) begin
        pipeV[0] <= imem_req & imem_gnt;
        pipeA[0] <= imem_addr;
        for (int i = 1; i < 8; i++) begin
            pipeV[i] <= pipeV[i-1];
            pipeA[i] <= pipeA[i-1];
        end
        if (imem_req && imem_gnt) issueCount <= issueCount + 1;
        if (dec_valid && dec_ready) popCount <= popCount + 1;
    end

    always_comb begin
        imem_rvalid = pipeV[lat-1];
        imem_rdata  = imem_rvalid ? instrOf(pipeA[lat-1]) : 32'hDEAD_BEEF;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        dec_ready      = rdy;
        #1;
    endtask

    // Hold reset long enough for the memory pipe to drain, then release mid-cycle.
    task automatic doReset(input int newLat);
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (9) nextCycle();
        lat      = newLat;
        imem_gnt = 1'b1;
        reset    = 1'b0;
        #1;
    endtask

    task automatic waitDec(input string tag, input logic [31:0] pc);
        int n = 0;
        while (!dec_valid && n < 30) begin
            nextCycle();
            n++;
        end
        checkOutput({tag, " valid"}, {31'h0, dec_valid}, 32'h1);
        checkOutput({tag, " pc"}, dec_pc, pc);
        checkOutput({tag, " instr"}, dec_instr, instrOf(pc));
    endtask

    initial begin
        imem_gnt       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
        #3;
        checkOutput("rst req", {31'h0, imem_req}, 32'h0);
        checkOutput("rst addr", imem_addr, 32'h0);
        checkOutput("rst valid", {31'h0, dec_valid}, 32'h0);
        checkOutput("rst instr", dec_instr, 32'h0);
        checkOutput("rst pc", dec_pc, 32'h0);

        // Streaming: one instruction per cycle from the third cycle after release.
        doReset(1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t1 req", {31'h0, imem_req}, 32'h1);
        checkOutput("t1 addr", imem_addr, 32'h0);
        checkOutput("t1 empty", {31'h0, dec_valid}, 32'h0);
        for (int k = 1; k <= 10; k++) begin
            nextCycle();
            if (k < 2) begin
                checkOutput("t1 bubble", {31'h0, dec_valid}, 32'h0);
            end else begin
                checkOutput("t1 valid", {31'h0, dec_valid}, 32'h1);
                checkOutput("t1 pc", dec_pc, 32'((k - 2) * 4));
                checkOutput("t1 instr", dec_instr, instrOf(32'((k - 2) * 4)));
            end
        end

        // Backpressure: the credit limit stops fetching at exactly DEPTH entries.
        doReset(1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        base = issueCount;
        repeat (20) nextCycle();
        checkOutput("t2 issues", 32'(issueCount - base), 32'd4);
        checkOutput("t2 req", {31'h0, imem_req}, 32'h0);
        checkOutput("t2 head", dec_pc, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("t2 valid", {31'h0, dec_valid}, 32'h1);
            checkOutput("t2 pc", dec_pc, 32'(k * 4));
            nextCycle();
        end

        // Redirect with two requests in flight under 3-cycle latency.
        doReset(3);
        applyStimulus(1'b0, 32'h0, 1'b0);
        nextCycle();
        nextCycle();
        applyStimulus(1'b1, 32'h100, 1'b1);
        checkOutput("t3 req", {31'h0, imem_req}, 32'h0);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t3 addr", imem_addr, 32'h100);
        checkOutput("t3 flushed", {31'h0, dec_valid}, 32'h0);
        waitDec("t3 first", 32'h100);
        nextCycle();
        waitDec("t3 second", 32'h104);

        // Redirect coinciding with a response and a decode pop.
        doReset(1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        base = popCount;
        repeat (5) nextCycle();
        checkOutput("t4 head", dec_pc, 32'hC);
        checkOutput("t4 rvalid", {31'h0, imem_rvalid}, 32'h1);
        applyStimulus(1'b1, 32'h200, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t4 pops", 32'(popCount - base), 32'd4);
        checkOutput("t4 empty", {31'h0, dec_valid}, 32'h0);
        checkOutput("t4 addr", imem_addr, 32'h200);
        checkOutput("t4 req", {31'h0, imem_req}, 32'h1);
        waitDec("t4 target", 32'h200);

        // Misaligned redirect near the top of the address space, then wrap.
        doReset(1);
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t5 addr", imem_addr, 32'hFFFF_FFFC);
        checkOutput("t5 req", {31'h0, imem_req}, 32'h1);
        nextCycle();
        checkOutput("t5 wrap", imem_addr, 32'h0);
        waitDec("t5 top", 32'hFFFF_FFFC);
        nextCycle();
        waitDec("t5 zero", 32'h0);

        // Reset mid-stream with a full FIFO clears outputs immediately.
        doReset(1);
        applyStimulus(1'b0, 32'h0, 1'b0);
        repeat (10) nextCycle();
        checkOutput("t6 full", {31'h0, dec_valid}, 32'h1);
        checkOutput("t6 stall", {31'h0, imem_req}, 32'h0);
        checkOutput("t6 prePc", imem_addr, 32'h10);
        reset = 1'b1;
        #1;
        checkOutput("t6 req", {31'h0, imem_req}, 32'h0);
        checkOutput("t6 addr", imem_addr, 32'h0);
        checkOutput("t6 valid", {31'h0, dec_valid}, 32'h0);
        checkOutput("t6 instr", dec_instr, 32'h0);
        checkOutput("t6 pc", dec_pc, 32'h0);
        repeat (8) nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("t6 restart", imem_addr, 32'h0);
        waitDec("t6 first", 32'h0);
        nextCycle();
        waitDec("t6 second", 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
